branch_issue_scheduler: RTL and testbench

Four-entry in-order-aged issue queue that shares the single branch evaluator among pending conditional branches in the out-of-order RV32I core. Dispatch allocates branches with possibly unready operands, and the queue wakes them up from the common data bus (CDB). Each cycle it sends the oldest fully-ready branch to the evaluator. It registers the resolved outcome, target and misprediction flag for the ROB and fetch redirect logic.

---
 rtl/branch_unit_pkg.sv | 48 ++++
 rtl/branch_rs_select.sv | 26 ++
 rtl/branch_issue_scheduler.sv | 163 ++++++++++++++++
 tb/tb_branch_issue_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// Shared types for the branch issue path: funct3 codes, queue entry layout
// and the CDB wakeup rule applied to each entry.
package branch_unit_pkg;

    localparam int BR_XLEN  = 32;
    localparam int BR_TAG_W = 5;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct packed {
        logic                valid;
        logic [2:0]          funct3;
        logic [BR_XLEN-1:0]  rs1_value;
        logic                rs1_ready;
        logic [BR_TAG_W-1:0] rs1_tag;
        logic [BR_XLEN-1:0]  rs2_value;
        logic                rs2_ready;
        logic [BR_TAG_W-1:0] rs2_tag;
        logic [BR_XLEN-1:0]  pc;
        logic [BR_XLEN-1:0]  imm;
        logic                pred_taken;
        logic [BR_TAG_W-1:0] rob_tag;
    } branch_rs_entry_t;

    // Only operands still waiting on their producer may capture a broadcast.
    function automatic branch_rs_entry_t wake(input branch_rs_entry_t e,
                                              input logic cdb_valid,
                                              input logic [BR_TAG_W-1:0] cdb_tag,
                                              input logic [BR_XLEN-1:0] cdb_value);
        branch_rs_entry_t r;
        r = e;
        if (cdb_valid && e.valid && !e.rs1_ready && e.rs1_tag == cdb_tag) begin
            r.rs1_value = cdb_value;
            r.rs1_ready = 1'b1;
        end
        if (cdb_valid && e.valid && !e.rs2_ready && e.rs2_tag == cdb_tag) begin
            r.rs2_value = cdb_value;
            r.rs2_ready = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_rs_select.sv
// Oldest-ready picker: grants the lowest-index requesting slot.
module branch_rs_select #(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_issue_scheduler.sv
// Compacting, age-ordered branch issue queue feeding one shared evaluator,
// with CDB wakeup and a registered resolve stage.
module branch_issue_scheduler
    import branch_unit_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int XLEN      = BR_XLEN,
    parameter int TAG_WIDTH = BR_TAG_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic [2:0]           alloc_funct3,
    input  logic [XLEN-1:0]      alloc_rs1_value,
    input  logic [XLEN-1:0]      alloc_rs2_value,
    input  logic                 alloc_rs1_ready,
    input  logic                 alloc_rs2_ready,
    input  logic [TAG_WIDTH-1:0] alloc_rs1_tag,
    input  logic [TAG_WIDTH-1:0] alloc_rs2_tag,
    input  logic [XLEN-1:0]      alloc_pc,
    input  logic [XLEN-1:0]      alloc_imm,
    input  logic                 alloc_pred_taken,
    input  logic [TAG_WIDTH-1:0] alloc_rob_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [XLEN-1:0]      cdb_value,
    output logic                 eval_valid,
    output logic [2:0]           eval_funct3,
    output logic [XLEN-1:0]      eval_rs1,
    output logic [XLEN-1:0]      eval_rs2,
    input  logic                 eval_taken,
    output logic                 res_valid,
    output logic [TAG_WIDTH-1:0] res_rob_tag,
    output logic                 res_taken,
    output logic [XLEN-1:0]      res_target,
    output logic                 res_mispredict
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    branch_rs_entry_t ent_q [DEPTH];
    branch_rs_entry_t ent_d [DEPTH];
    branch_rs_entry_t woken [DEPTH];
    branch_rs_entry_t new_ent;
    branch_rs_entry_t iss_ent;

    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     req, grant;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;
    logic                 alloc_fire;

    logic                 res_valid_q, res_valid_d;
    logic [TAG_WIDTH-1:0] res_rob_tag_q, res_rob_tag_d;
    logic                 res_taken_q, res_taken_d;
    logic [XLEN-1:0]      res_target_q, res_target_d;
    logic                 res_mispredict_q, res_mispredict_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            req[i] = ent_q[i].valid && ent_q[i].rs1_ready && ent_q[i].rs2_ready;
    end

    branch_rs_select #(.DEPTH(DEPTH)) u_select (
        .req   (req),
        .grant (grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign iss_ent     = ent_q[sel_idx];
    assign alloc_ready = count_q < CNT_W'(DEPTH);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign eval_valid  = sel_any;
    assign eval_funct3 = iss_ent.funct3;
    assign eval_rs1    = iss_ent.rs1_value;
    assign eval_rs2    = iss_ent.rs2_value;

    always_comb begin
        new_ent            = '0;
        new_ent.valid      = 1'b1;
        new_ent.funct3     = alloc_funct3;
        new_ent.rs1_value  = alloc_rs1_value;
        new_ent.rs1_ready  = alloc_rs1_ready;
        new_ent.rs1_tag    = alloc_rs1_tag;
        new_ent.rs2_value  = alloc_rs2_value;
        new_ent.rs2_ready  = alloc_rs2_ready;
        new_ent.rs2_tag    = alloc_rs2_tag;
        new_ent.pc         = alloc_pc;
        new_ent.imm        = alloc_imm;
        new_ent.pred_taken = alloc_pred_taken;
        new_ent.rob_tag    = alloc_rob_tag;
        // Bypass: an operand broadcast in its allocation cycle is never seen again.
        new_ent = wake(new_ent, cdb_valid, cdb_tag, cdb_value);

        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_value);
            ent_d[i] = woken[i];
        end
        count_d = count_q;

        if (sel_any) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (i >= int'(sel_idx)) ent_d[i] = woken[i+1];
            ent_d[DEPTH-1] = '0;
            count_d        = count_q - 1'b1;
        end

        if (alloc_fire) begin
            ent_d[count_d[IDX_W-1:0]] = new_ent;
            count_d                   = count_d + 1'b1;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    always_comb begin
        res_valid_d      = sel_any && !flush;
        res_rob_tag_d    = res_rob_tag_q;
        res_taken_d      = res_taken_q;
        res_target_d     = res_target_q;
        res_mispredict_d = res_mispredict_q;
        if (sel_any) begin
            res_rob_tag_d    = iss_ent.rob_tag;
            res_taken_d      = eval_taken;
            res_target_d     = eval_taken ? iss_ent.pc + iss_ent.imm : iss_ent.pc + XLEN'(4);
            res_mispredict_d = eval_taken ^ iss_ent.pred_taken;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q          <= '0;
            res_valid_q      <= 1'b0;
            res_rob_tag_q    <= '0;
            res_taken_q      <= 1'b0;
            res_target_q     <= '0;
            res_mispredict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q          <= count_d;
            res_valid_q      <= res_valid_d;
            res_rob_tag_q    <= res_rob_tag_d;
            res_taken_q      <= res_taken_d;
            res_target_q     <= res_target_d;
            res_mispredict_q <= res_mispredict_d;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_rob_tag    = res_rob_tag_q;
    assign res_taken      = res_taken_q;
    assign res_target     = res_target_q;
    assign res_mispredict = res_mispredict_q;

endmodule

// File: tb/tb_branch_issue_scheduler.sv
// Directed bench for branch_issue_scheduler with a behavioural branch evaluator.
module tb_branch_issue_scheduler;
    import branch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [2:0]  alloc_funct3 = '0;
    logic [31:0] alloc_rs1_value = '0, alloc_rs2_value = '0;
    logic        alloc_rs1_ready = 1'b0, alloc_rs2_ready = 1'b0;
    logic [4:0]  alloc_rs1_tag = '0, alloc_rs2_tag = '0;
    logic [31:0] alloc_pc = '0, alloc_imm = '0;
    logic        alloc_pred_taken = 1'b0;
    logic [4:0]  alloc_rob_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic        eval_valid;
    logic [2:0]  eval_funct3;
    logic [31:0] eval_rs1, eval_rs2;
    logic        eval_taken;
    logic        res_valid;
    logic [4:0]  res_rob_tag;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_mispredict;

    int n_cmp = 0;
    int n_err = 0;

    branch_issue_scheduler #(.DEPTH(4), .XLEN(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_funct3(alloc_funct3),
        .alloc_rs1_value(alloc_rs1_value), .alloc_rs2_value(alloc_rs2_value),
        .alloc_rs1_ready(alloc_rs1_ready), .alloc_rs2_ready(alloc_rs2_ready),
        .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
        .alloc_pc(alloc_pc), .alloc_imm(alloc_imm), .alloc_pred_taken(alloc_pred_taken),
        .alloc_rob_tag(alloc_rob_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .eval_valid(eval_valid), .eval_funct3(eval_funct3), .eval_rs1(eval_rs1),
        .eval_rs2(eval_rs2), .eval_taken(eval_taken),
        .res_valid(res_valid), .res_rob_tag(res_rob_tag), .res_taken(res_taken),
        .res_target(res_target), .res_mispredict(res_mispredict)
    );

    always #5 clk = ~clk;

    // External evaluator model
    always_comb begin
        case (eval_funct3)
            BEQ:     eval_taken = (eval_rs1 == eval_rs2);
            BNE:     eval_taken = (eval_rs1 != eval_rs2);
            BLT:     eval_taken = ($signed(eval_rs1) <  $signed(eval_rs2));
            BGE:     eval_taken = ($signed(eval_rs1) >= $signed(eval_rs2));
            BLTU:    eval_taken = (eval_rs1 <  eval_rs2);
            BGEU:    eval_taken = (eval_rs1 >= eval_rs2);
            default: eval_taken = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] f3,
                         input logic [31:0] v1, input logic r1, input logic [4:0] t1,
                         input logic [31:0] v2, input logic r2, input logic [4:0] t2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic [4:0] rob);
        alloc_valid = 1'b1; alloc_funct3 = f3;
        alloc_rs1_value = v1; alloc_rs1_ready = r1; alloc_rs1_tag = t1;
        alloc_rs2_value = v2; alloc_rs2_ready = r2; alloc_rs2_tag = t2;
        alloc_pc = pc; alloc_imm = imm; alloc_pred_taken = pred; alloc_rob_tag = rob;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    endtask

    task automatic test_reset();
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ready got %0b exp 1", alloc_ready); end
        n_cmp++; if (eval_valid !== 1'b0) begin n_err++; $display("FAIL rst_eval_valid got %0b exp 0", eval_valid); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %0b exp 0", res_valid); end
        n_cmp++; if (res_target !== 32'h0) begin n_err++; $display("FAIL rst_res_target got %h exp 0", res_target); end
    endtask

    task automatic test_basic_issue();
        alloc(BEQ, 32'd5, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'h100, 32'h20, 1'b0, 5'd1);
        #1;
        n_cmp++; if (eval_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_same_cycle got %0b exp 0", eval_valid); end
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1) begin n_err++; $display("FAIL basic_eval_valid got %0b exp 1", eval_valid); end
        n_cmp++; if (eval_rs1 !== 32'd5) begin n_err++; $display("FAIL basic_eval_rs1 got %0d exp 5", eval_rs1); end
        tick();
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL basic_res_valid got %0b exp 1", res_valid); end
        n_cmp++; if (res_taken !== 1'b1) begin n_err++; $display("FAIL basic_res_taken got %0b exp 1", res_taken); end
        n_cmp++; if (res_target !== 32'h120) begin n_err++; $display("FAIL basic_res_target got %h exp 120", res_target); end
        n_cmp++; if (res_mispredict !== 1'b1) begin n_err++; $display("FAIL basic_mispredict got %0b exp 1", res_mispredict); end
        n_cmp++; if (res_rob_tag !== 5'd1) begin n_err++; $display("FAIL basic_rob_tag got %0d exp 1", res_rob_tag); end
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL basic_res_pulse got %0b exp 0", res_valid); end
    endtask

    task automatic test_out_of_order();
        alloc(BLT, 32'd0, 1'b0, 5'd3, 32'd1, 1'b1, 5'd0, 32'h200, 32'h40, 1'b0, 5'd1);
        tick();
        alloc(BNE, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'h300, 32'h8, 1'b1, 5'd2);
        #1;
        n_cmp++; if (eval_valid !== 1'b0) begin n_err++; $display("FAIL ooo_blt_waits got %0b exp 0", eval_valid); end
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1 || eval_funct3 !== BNE) begin n_err++; $display("FAIL ooo_bne_first got v=%0b f3=%0d exp v=1 f3=1", eval_valid, eval_funct3); end
        tick();
        cdb(5'd3, 32'hFFFF_FFFF);
        n_cmp++; if (res_rob_tag !== 5'd2 || res_target !== 32'h308 || res_mispredict !== 1'b0)
            begin n_err++; $display("FAIL ooo_bne_res got rob=%0d tgt=%h mp=%0b exp rob=2 tgt=308 mp=0", res_rob_tag, res_target, res_mispredict); end
        #1;
        n_cmp++; if (eval_valid !== 1'b0) begin n_err++; $display("FAIL ooo_wake_not_same_cycle got %0b exp 0", eval_valid); end
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1 || eval_rs1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ooo_blt_issue got v=%0b rs1=%h exp v=1 rs1=ffffffff", eval_valid, eval_rs1); end
        tick();
        n_cmp++; if (res_valid !== 1'b1 || res_rob_tag !== 5'd1 || res_taken !== 1'b1 || res_target !== 32'h240 || res_mispredict !== 1'b1)
            begin n_err++; $display("FAIL ooo_blt_res got v=%0b rob=%0d tk=%0b tgt=%h mp=%0b exp 1/1/1/240/1", res_valid, res_rob_tag, res_taken, res_target, res_mispredict); end
    endtask

    task automatic test_bypass_wakeup();
        alloc(BGE, 32'd10, 1'b1, 5'd0, 32'd0, 1'b0, 5'd7, 32'h400, 32'hFFFF_FFF8, 1'b1, 5'd3);
        cdb(5'd7, 32'd9);
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1 || eval_rs2 !== 32'd9) begin n_err++; $display("FAIL bypass_issue got v=%0b rs2=%0d exp v=1 rs2=9", eval_valid, eval_rs2); end
        tick();
        n_cmp++; if (res_taken !== 1'b1 || res_target !== 32'h3F8 || res_mispredict !== 1'b0)
            begin n_err++; $display("FAIL bypass_res got tk=%0b tgt=%h mp=%0b exp 1/3f8/0", res_taken, res_target, res_mispredict); end
    endtask

    task automatic test_full_and_compact();
        for (int i = 0; i < 4; i++) begin
            alloc(BEQ, 32'd0, 1'b0, 5'(10 + i), 32'd0, 1'b1, 5'd0, 32'h1040 + 32'(i) * 32'h10, 32'h4, 1'b1, 5'(4 + i));
            tick();
        end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_alloc_ready got %0b exp 0", alloc_ready); end
        alloc(BEQ, 32'd0, 1'b0, 5'd22, 32'd0, 1'b1, 5'd0, 32'h1090, 32'h4, 1'b1, 5'd9);
        cdb(5'd12, 32'd0);
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1 || alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_issue_ready got v=%0b rdy=%0b exp v=1 rdy=0", eval_valid, alloc_ready); end
        tick();
        n_cmp++; if (res_rob_tag !== 5'd6 || res_target !== 32'h1064) begin n_err++; $display("FAIL full_slot2_res got rob=%0d tgt=%h exp 6/1064", res_rob_tag, res_target); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_return got %0b exp 1", alloc_ready); end
        alloc(BEQ, 32'd0, 1'b0, 5'd21, 32'd0, 1'b1, 5'd0, 32'h1080, 32'h4, 1'b1, 5'd8);
        tick(); idle(); #1;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_count3_refill got %0b exp 0", alloc_ready); end
        cdb(5'd13, 32'd0);
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1) begin n_err++; $display("FAIL full_shifted_issue got %0b exp 1", eval_valid); end
        tick();
        n_cmp++; if (res_rob_tag !== 5'd7 || res_target !== 32'h1074) begin n_err++; $display("FAIL full_shifted_res got rob=%0d tgt=%h exp 7/1074", res_rob_tag, res_target); end
    endtask

    task automatic test_flush();
        cdb(5'd10, 32'd0);
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b1) begin n_err++; $display("FAIL flush_inflight got %0b exp 1", eval_valid); end
        flush = 1'b1;
        tick(); idle(); #1;
        n_cmp++; if (res_valid !== 1'b0 || alloc_ready !== 1'b1 || eval_valid !== 1'b0)
            begin n_err++; $display("FAIL flush_clear got rv=%0b rdy=%0b ev=%0b exp 0/1/0", res_valid, alloc_ready, eval_valid); end
        cdb(5'd11, 32'd0);
        tick(); idle(); #1;
        n_cmp++; if (eval_valid !== 1'b0) begin n_err++; $display("FAIL flush_entries_gone got %0b exp 0", eval_valid); end
    endtask

    task automatic test_async_reset();
        alloc(BEQ, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'h500, 32'h10, 1'b0, 5'd10);
        tick();
        alloc(BEQ, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'h600, 32'h10, 1'b0, 5'd11);
        tick(); idle(); #1;
        n_cmp++; if (res_valid !== 1'b1 || eval_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre got rv=%0b ev=%0b exp 1/1", res_valid, eval_valid); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (res_valid !== 1'b0 || eval_valid !== 1'b0 || res_target !== 32'h0 || res_rob_tag !== 5'd0 || alloc_ready !== 1'b1)
            begin n_err++; $display("FAIL areset_immediate got rv=%0b ev=%0b tgt=%h rob=%0d rdy=%0b exp 0/0/0/0/1", res_valid, eval_valid, res_target, res_rob_tag, alloc_ready); end
        #1 reset_n = 1'b1;
        tick();
        n_cmp++; if (eval_valid !== 1'b0 || res_valid !== 1'b0 || alloc_ready !== 1'b1)
            begin n_err++; $display("FAIL areset_empty got ev=%0b rv=%0b rdy=%0b exp 0/0/1", eval_valid, res_valid, alloc_ready); end
    endtask

    initial begin
        #12 reset_n = 1'b1;
        test_reset();
        tick();
        test_basic_issue();
        test_out_of_order();
        test_bypass_wakeup();
        test_full_and_compact();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
